// File: rtl/multi_ch_fifo.sv
// multi_ch_fifo: NUM_CH independent ring-buffer FIFOs on one clock; define FIFO_FWFT_EN for first-word-fall-through reads
module multi_ch_fifo #(
  parameter int NUM_CH = 4,
  parameter int DEPTH = 8,
  parameter int DATA_WIDTH = 16,
  parameter int AFULL_TH = DEPTH - 2,
  parameter int AEMPTY_TH = 1,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_CH-1:0]            fifo_wen,
  input  logic [NUM_CH-1:0]            fifo_ren,
  input  logic [NUM_CH*DATA_WIDTH-1:0] fifo_din,
  output logic [NUM_CH*DATA_WIDTH-1:0] fifo_dout,
  output logic [NUM_CH-1:0]            fifo_full,
  output logic [NUM_CH-1:0]            fifo_empty,
  output logic [NUM_CH-1:0]            fifo_afull,
  output logic [NUM_CH-1:0]            fifo_aempty,
  output logic [NUM_CH*CW-1:0]         fifo_count,
  input  logic                         err_clr,
  output logic [NUM_CH-1:0]            ovf_err,
  output logic [NUM_CH-1:0]            udf_err
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C = CW'(AFULL_TH);
  localparam logic [CW-1:0] AE_C = CW'(AEMPTY_TH);
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] cnt, cnt_nxt;
    logic full, empty, afull, aempty, ovf, udf, push, pop;
    assign pop = fifo_ren[g] & ~empty;
    assign push = fifo_wen[g] & (~full | pop);
    assign cnt_nxt = cnt + CW'(push) - CW'(pop);
    always_ff @(posedge clk) begin
      if (rst) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        cnt <= '0;
        full <= 1'b0;
        empty <= 1'b1;
        afull <= 1'b0;
        aempty <= 1'b1;
        ovf <= 1'b0;
        udf <= 1'b0;
      end else begin
        wr_ptr <= push ? wr_ptr + 1'b1 : wr_ptr;
        rd_ptr <= pop ? rd_ptr + 1'b1 : rd_ptr;
        cnt <= cnt_nxt;
        full <= cnt_nxt == FULL_C;
        empty <= cnt_nxt == '0;
        afull <= cnt_nxt >= AF_C;
        aempty <= cnt_nxt <= AE_C;
        ovf <= (ovf & ~err_clr) | (fifo_wen[g] & ~push);
        udf <= (udf & ~err_clr) | (fifo_ren[g] & empty);
      end
    end
    always_ff @(posedge clk)
      if (!rst && push) mem[wr_ptr] <= fifo_din[g*DATA_WIDTH +: DATA_WIDTH];
`ifdef FIFO_FWFT_EN
    assign fifo_dout[g*DATA_WIDTH +: DATA_WIDTH] = mem[rd_ptr];
`else
    logic [DATA_WIDTH-1:0] dout;
    always_ff @(posedge clk)
      if (rst) dout <= '0;
      else if (pop) dout <= mem[rd_ptr];
    assign fifo_dout[g*DATA_WIDTH +: DATA_WIDTH] = dout;
`endif
    assign fifo_full[g] = full;
    assign fifo_empty[g] = empty;
    assign fifo_afull[g] = afull;
    assign fifo_aempty[g] = aempty;
    assign fifo_count[g*CW +: CW] = cnt;
    assign ovf_err[g] = ovf;
    assign udf_err[g] = udf;
  end
endmodule

// File: tb/tb_multi_ch_fifo.sv
// tb_multi_ch_fifo: directed and random traffic against a queue-based reference model
module tb_multi_ch_fifo;
  localparam int NC = 4, D = 8, DW = 16, CW = 4;
  logic clk = 1'b0, rst = 1'b1, err_clr = 1'b0;
  logic [NC-1:0] fifo_wen = '0, fifo_ren = '0;
  logic [NC*DW-1:0] fifo_din = '0, fifo_dout;
  logic [NC-1:0] fifo_full, fifo_empty, fifo_afull, fifo_aempty, ovf_err, udf_err;
  logic [NC*CW-1:0] fifo_count;
  int n_assert = 0, n_fail = 0;
  logic [DW-1:0] q [NC][$];
  logic [DW-1:0] m_dout [NC];
  logic m_ovf [NC], m_udf [NC];

  multi_ch_fifo #(.NUM_CH(NC), .DEPTH(D), .DATA_WIDTH(DW), .AFULL_TH(D-2), .AEMPTY_TH(1)) dut (
    .clk(clk), .rst(rst), .fifo_wen(fifo_wen), .fifo_ren(fifo_ren), .fifo_din(fifo_din),
    .fifo_dout(fifo_dout), .fifo_full(fifo_full), .fifo_empty(fifo_empty), .fifo_afull(fifo_afull),
    .fifo_aempty(fifo_aempty), .fifo_count(fifo_count), .err_clr(err_clr), .ovf_err(ovf_err), .udf_err(udf_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NC*DW-1:0] pk(input int ch, input logic [DW-1:0] v);
    logic [NC*DW-1:0] r;
    r = '0;
    r[ch*DW +: DW] = v;
    return r;
  endfunction

  task automatic check_all(input string tag);
    for (int c = 0; c < NC; c++) begin
      int sz;
      sz = q[c].size();
      chk({tag, "/count"}, 64'(fifo_count[c*CW +: CW]), 64'(sz));
      chk({tag, "/full"}, 64'(fifo_full[c]), 64'(sz == D));
      chk({tag, "/empty"}, 64'(fifo_empty[c]), 64'(sz == 0));
      chk({tag, "/afull"}, 64'(fifo_afull[c]), 64'(sz >= D - 2));
      chk({tag, "/aempty"}, 64'(fifo_aempty[c]), 64'(sz <= 1));
      chk({tag, "/ovf"}, 64'(ovf_err[c]), 64'(m_ovf[c]));
      chk({tag, "/udf"}, 64'(udf_err[c]), 64'(m_udf[c]));
`ifdef FIFO_FWFT_EN
      if (sz > 0) chk({tag, "/head"}, 64'(fifo_dout[c*DW +: DW]), 64'(q[c][0]));
`else
      chk({tag, "/dout"}, 64'(fifo_dout[c*DW +: DW]), 64'(m_dout[c]));
`endif
    end
  endtask

  task automatic step(input string tag, input logic [NC-1:0] w, input logic [NC-1:0] r,
                      input logic [NC*DW-1:0] d, input logic clr, input logic rs);
    fifo_wen = w;
    fifo_ren = r;
    fifo_din = d;
    err_clr = clr;
    rst = rs;
    @(posedge clk);
    for (int c = 0; c < NC; c++) begin
      logic po, pu;
      int sz;
      sz = q[c].size();
      if (rs) begin
        q[c].delete();
        m_dout[c] = '0;
        m_ovf[c] = 1'b0;
        m_udf[c] = 1'b0;
      end else begin
        po = r[c] && sz > 0;
        pu = w[c] && (sz < D || po);
        if (po) m_dout[c] = q[c].pop_front();
        if (pu) q[c].push_back(d[c*DW +: DW]);
        m_ovf[c] = (m_ovf[c] && !clr) || (w[c] && !pu);
        m_udf[c] = (m_udf[c] && !clr) || (r[c] && sz == 0);
      end
    end
    #1;
    check_all(tag);
  endtask

  initial begin
    logic [NC*DW-1:0] d;
    logic [NC-1:0] w, r;
    step("rst", '0, '0, '0, 1'b0, 1'b1);
    step("rst", '0, '0, '0, 1'b0, 1'b1);
    step("idle", '0, '0, '0, 1'b0, 1'b0);
    chk("idle_empty", 64'(fifo_empty), 64'(4'hF));
    chk("idle_aempty", 64'(fifo_aempty), 64'(4'hF));
    chk("idle_full", 64'(fifo_full | fifo_afull), 64'(0));
    chk("idle_dout", 64'(fifo_dout), 64'(0));
    chk("idle_err", 64'(ovf_err | udf_err), 64'(0));
    for (int i = 1; i <= 8; i++) begin
      step("ch0_push", 4'b0001, '0, pk(0, 16'(i)), 1'b0, 1'b0);
      chk("ch0_afull", 64'(fifo_afull[0]), 64'(i >= 6));
    end
    chk("ch0_full", 64'(fifo_full[0]), 64'(1));
    chk("ch0_count8", 64'(fifo_count[3:0]), 64'(8));
    step("ch0_ovf", 4'b0001, '0, pk(0, 16'h0009), 1'b0, 1'b0);
    chk("ch0_ovf_bit", 64'(ovf_err[0]), 64'(1));
    chk("ch0_count_hold", 64'(fifo_count[3:0]), 64'(8));
    for (int i = 1; i <= 8; i++) begin
`ifdef FIFO_FWFT_EN
      chk("ch0_head_seq", 64'(fifo_dout[15:0]), 64'(i));
`endif
      step("ch0_pop", '0, 4'b0001, '0, 1'b0, 1'b0);
`ifndef FIFO_FWFT_EN
      chk("ch0_pop_seq", 64'(fifo_dout[15:0]), 64'(i));
`endif
    end
    chk("ch0_drained", 64'(fifo_empty[0]), 64'(1));
    for (int i = 0; i < 8; i++) step("ch1_fill", 4'b0010, '0, pk(1, 16'(16'h0010 + i)), 1'b0, 1'b0);
    step("ch1_pushpop_full", 4'b0010, 4'b0010, pk(1, 16'h00AA), 1'b0, 1'b0);
    chk("ch1_count_stay", 64'(fifo_count[7:4]), 64'(8));
    chk("ch1_no_ovf", 64'(ovf_err[1]), 64'(0));
    for (int i = 0; i < 8; i++) begin
`ifdef FIFO_FWFT_EN
      if (i == 7) chk("ch1_last_head", 64'(fifo_dout[31:16]), 64'(16'h00AA));
`endif
      step("ch1_drain", '0, 4'b0010, '0, 1'b0, 1'b0);
    end
`ifndef FIFO_FWFT_EN
    chk("ch1_last_out", 64'(fifo_dout[31:16]), 64'(16'h00AA));
`endif
    for (int i = 0; i < 20; i++) begin
      step("ch2_wrap_push", 4'b0100, '0, pk(2, 16'(16'h0200 + i)), 1'b0, 1'b0);
      chk("ch2_count1", 64'(fifo_count[11:8]), 64'(1));
      step("ch2_wrap_pop", '0, 4'b0100, '0, 1'b0, 1'b0);
      chk("ch2_count0", 64'(fifo_count[11:8]), 64'(0));
    end
    step("ch3_udf", '0, 4'b1000, '0, 1'b0, 1'b0);
    chk("ch3_udf_set", 64'(udf_err[3]), 64'(1));
    step("ch3_clr", '0, '0, '0, 1'b1, 1'b0);
    chk("ch3_udf_clr", 64'(udf_err[3]), 64'(0));
    step("ch3_clr_and_udf", '0, 4'b1000, '0, 1'b1, 1'b0);
    chk("ch3_set_wins", 64'(udf_err[3]), 64'(1));
    step("ch3_empty_pushpop", 4'b1000, 4'b1000, pk(3, 16'h0333), 1'b1, 1'b0);
    chk("ch3_count1", 64'(fifo_count[15:12]), 64'(1));
    chk("ch3_udf_again", 64'(udf_err[3]), 64'(1));
    for (int i = 0; i < 600; i++) begin
      d = {$urandom, $urandom};
      w = 4'($urandom);
      r = 4'($urandom);
      if ((i / 75) % 2 == 0) begin
        w = w | 4'($urandom);
        r = r & 4'($urandom);
      end else begin
        w = w & 4'($urandom);
        r = r | 4'($urandom);
      end
      step("rand", w, r, d, $urandom_range(0, 24) == 0, i == 300);
      if (i == 300) begin
        chk("rand_rst_empty", 64'(fifo_empty), 64'(4'hF));
        chk("rand_rst_count", 64'(fifo_count), 64'(0));
      end
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/multi_ch_fifo.md
# multi_ch_fifo

Parametrised multi-channel synchronous FIFO. It provides NUM_CH independent ring-buffer FIFOs behind one clock, each with its own fill count, almost-full/almost-empty flags and sticky overflow/underflow error bits. It is the next generation of the single-channel FIFO read/write interface, and sits between the wavefront/traceback producers and the BRAM write masters. Use it wherever per-lane buffering is needed without instantiating separate FIFOs.

## Interface
Parameters:
- NUM_CH, 4: number of independent channels (≥1).
- DEPTH, 8: entries per channel; power of two, ≥2.
- DATA_WIDTH, 16: bits per entry.
- AFULL_TH, DEPTH-2: almost-full asserted when count ≥ AFULL_TH (1..DEPTH).
- AEMPTY_TH, 1: almost-empty asserted when count ≤ AEMPTY_TH (0..DEPTH-1).
- Derived: CW = $clog2(DEPTH)+1.

Ports:
- clk  in  1  sole clock; all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- fifo_wen  in  NUM_CH  per-channel push request.
- fifo_ren  in  NUM_CH  per-channel pop request.
- fifo_din  in  NUM_CH*DATA_WIDTH  channel c at bits [c*DATA_WIDTH +: DATA_WIDTH].
- fifo_dout  out  NUM_CH*DATA_WIDTH  same packing.
- fifo_full  out  NUM_CH  count == DEPTH.
- fifo_empty  out  NUM_CH  count == 0.
- fifo_afull  out  NUM_CH  count ≥ AFULL_TH.
- fifo_aempty  out  NUM_CH  count ≤ AEMPTY_TH.
- fifo_count  out  NUM_CH*CW  occupancy, channel c at [c*CW +: CW].
- err_clr  in  1  clears all sticky error bits.
- ovf_err  out  NUM_CH  sticky: push dropped.
- udf_err  out  NUM_CH  sticky: pop ignored.

## Operation
- Per channel: DEPTH×DATA_WIDTH storage, log2(DEPTH)-bit wr_ptr/rd_ptr, CW-bit count. Channels are fully independent; there is no cross-channel arbitration.
- Push accepted = fifo_wen & (!full | pop accepted). An accepted push writes din at wr_ptr, and wr_ptr increments modulo DEPTH (natural wrap).
- Pop accepted = fifo_ren & !empty. An accepted pop increments rd_ptr modulo DEPTH.
- Count update:
  - +1 on push only.
  - −1 on pop only.
  - Unchanged on both or neither.
  - Count never exceeds DEPTH and never underflows.
- Full with simultaneous push and pop: both accepted; count stays at DEPTH.
- Empty with simultaneous push and pop: push accepted, pop ignored; count becomes 1 and udf_err sets.
- fifo_wen while full without an accepted pop: data dropped, ovf_err[c] sets.
- fifo_ren while empty: ignored, udf_err[c] sets, dout holds its previous value.
- Errors stay set until err_clr or rst. If err_clr and a new error occur in the same cycle, the error bit is set (set wins).
- Flags and count are registered and reflect the state after the current edge. They are derived from the next count, so they are never a cycle stale.
- Storage is not reset; only pointers, counts, flags, errors and dout are reset.

## Timing
- Reset values: count=0, empty=1, aempty=1, full=0, afull=0 (AFULL_TH ≥ 1), dout=0, ovf_err=0, udf_err=0, pointers=0. Reset takes priority over all requests in the same cycle.
- Push at edge N: count/flags update at N. Without FIFO_FWFT_EN, the word is readable by a ren issued in cycle N+1 at the earliest.
- Standard read (macro absent): ren accepted at edge N → dout holds the popped word from edge N until the next accepted pop. Latency is 1 cycle.
- rst asserted mid-stream: all channels return to empty at the next edge. In-flight push/pop in that cycle are discarded.

## Configuration
- FIFO_FWFT_EN defined: first-word-fall-through.
  - dout[c] combinationally shows mem[rd_ptr] whenever !empty, so the head is visible the cycle after the push edge.
  - ren acknowledges and advances to the next word.
  - dout is don't-care while empty; the bench checks it only when !empty.
- FIFO_FWFT_EN undefined: registered-output standard mode as above.
- All flag, count and error behaviour is identical in both modes.

## Test plan
- Reset, then idle: every channel shows count=0, empty=1, aempty=1, full=0, afull=0, dout=0 and no errors.
- DEPTH=8, channel 0: push 0x0001..0x0008 → full=1, afull=1 from count 6, count=8. A 9th push → dropped, ovf_err[0]=1, count stays 8. Pop 8 times → dout sequence 0x0001..0x0008, then empty=1.
- Channel 1 full, push 0x00AA and pop in the same cycle → count stays 8. After draining, 0x00AA is the last word out.
- Wrap-around: 20 alternating push/pop pairs on channel 2 → data in order, pointers wrap twice, count oscillates between 0 and 1.
- Pop on empty channel 3 → udf_err[3]=1, dout unchanged. Then err_clr=1 → udf_err[3]=0. err_clr together with a new empty pop → udf_err[3] stays 1.
- Random concurrent traffic on all 4 channels, rst pulsed mid-stream → all channels empty the next cycle, no cross-channel corruption against a scoreboard. Run in both FIFO_FWFT_EN builds.
